// File: rtl/regfile_pkg.sv
// Shared defaults and grant encoding for the register-file writeback controller.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package regfile_pkg;

  localparam int RF_DATA_BITS = 32;
  localparam int RF_ADDR_BITS = 5;
  localparam int RF_DEPTH     = 2 ** RF_ADDR_BITS;

  // Which requester won the most recent contention.
  typedef enum logic {
    GNT_A = 1'b0,
    GNT_B = 1'b1
  } grant_e;

endpackage

// File: rtl/wb_rr_arbiter.sv
// Two-way round-robin grant between the ALU (A) and mul/div/load (B) writeback requesters.
// Latency: ready is combinational from valid in the same cycle; last_grant updates at the edge.
// Backpressure: the loser of a contention sees ready low and holds its payload; both readies low in reset.
module wb_rr_arbiter
  import regfile_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic i_a_valid,
  input  logic i_b_valid,
  output logic o_a_ready,
  output logic o_b_ready
);

  grant_e r_last_grant;
  logic   w_contend;

  assign w_contend = i_a_valid && i_b_valid;

  // A lone requester is granted outright; on contention the previous loser wins.
  assign o_a_ready = !rst && i_a_valid && (!i_b_valid || (r_last_grant == GNT_B));
  assign o_b_ready = !rst && i_b_valid && (!i_a_valid || (r_last_grant == GNT_A));

  // Remember the contention winner; uncontended grants leave the history alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_grant <= GNT_B;
    end else if (w_contend) begin
      r_last_grant <= (r_last_grant == GNT_B) ? GNT_A : GNT_B;
    end
  end

endmodule

// File: rtl/regfile_wb_ctrl.sv
// Writeback arbitration, registered register-file write port and busy scoreboard for issue.
// Latency: accepted writeback appears on the write port one cycle later; iss_stall is combinational.
// Backpressure: a_ready/b_ready via round-robin arbiter; issue stalls on RAW/WAW against pending writes.
module regfile_wb_ctrl
  import regfile_pkg::*;
#(
  parameter  int DATA_BITS = RF_DATA_BITS,
  parameter  int ADDR_BITS = RF_ADDR_BITS,
  localparam int DEPTH     = 2 ** ADDR_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 iss_valid,
  input  logic [ADDR_BITS-1:0] iss_rs,
  input  logic [ADDR_BITS-1:0] iss_rt,
  input  logic [ADDR_BITS-1:0] iss_rd,
  input  logic                 iss_rd_we,
  output logic                 iss_stall,
  input  logic                 a_valid,
  input  logic [ADDR_BITS-1:0] a_addr,
  input  logic [DATA_BITS-1:0] a_data,
  output logic                 a_ready,
  input  logic                 b_valid,
  input  logic [ADDR_BITS-1:0] b_addr,
  input  logic [DATA_BITS-1:0] b_data,
  output logic                 b_ready,
  output logic                 WriteEnable,
  output logic [ADDR_BITS-1:0] DAddress,
  output logic [DATA_BITS-1:0] DData,
  output logic [DEPTH-1:0]     busy
);

  logic                 r_wr_en;
  logic [ADDR_BITS-1:0] r_wr_addr;
  logic [DATA_BITS-1:0] r_wr_data;
  logic [DEPTH-1:0]     r_busy;

  logic                 w_a_xfer;
  logic                 w_b_xfer;
  logic [ADDR_BITS-1:0] w_wb_addr;
  logic [DATA_BITS-1:0] w_wb_data;
  logic                 w_issue_fire;
  logic [DEPTH-1:0]     w_set_mask;
  logic [DEPTH-1:0]     w_clr_mask;
  logic [DEPTH-1:0]     w_busy_next;

  wb_rr_arbiter u_arb (
    .clk       (clk),
    .rst       (rst),
    .i_a_valid (a_valid),
    .i_b_valid (b_valid),
    .o_a_ready (a_ready),
    .o_b_ready (b_ready)
  );

  assign w_a_xfer  = a_valid && a_ready;
  assign w_b_xfer  = b_valid && b_ready;
  assign w_wb_addr = w_a_xfer ? a_addr : b_addr;
  assign w_wb_data = w_a_xfer ? a_data : b_data;

  // A source or the destination still awaiting its file write blocks issue.
  assign iss_stall    = iss_valid && (r_busy[iss_rs] || r_busy[iss_rt] || (iss_rd_we && r_busy[iss_rd]));
  assign w_issue_fire = iss_valid && !iss_stall;

  // Scoreboard edits: issuing marks the destination, the file write in progress releases its target.
  always_comb begin
    w_set_mask = '0;
    w_clr_mask = '0;
    if (w_issue_fire && iss_rd_we && (iss_rd != '0)) begin
      w_set_mask[iss_rd] = 1'b1;
    end
    if (r_wr_en) begin
      w_clr_mask[r_wr_addr] = 1'b1;
    end
  end

  // Set is applied after clear so a same-edge reissue keeps the register pending.
  assign w_busy_next = (r_busy & ~w_clr_mask) | w_set_mask;

  // Scoreboard register; register 0 is never pending.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy <= '0;
    end else begin
      r_busy <= {w_busy_next[DEPTH-1:1], 1'b0};
    end
  end

  // Write port: one-cycle registered copy of the accepted writeback; writes to register 0 are swallowed.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
    end else if (w_a_xfer || w_b_xfer) begin
      r_wr_en   <= (w_wb_addr != '0);
      r_wr_addr <= w_wb_addr;
      r_wr_data <= w_wb_data;
    end else begin
      r_wr_en   <= 1'b0;
    end
  end

  assign WriteEnable = r_wr_en;
  assign DAddress    = r_wr_addr;
  assign DData       = r_wr_data;
  assign busy        = r_busy;

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Self-checking bench for regfile_wb_ctrl: directed vector table, then constrained-random traffic.
// Latency: checks readies/stall mid-cycle and the write port/scoreboard one cycle after each edge.
// Backpressure: random requesters hold valid and payload while not granted.
module tb_regfile_wb_ctrl;

  logic        clk;
  logic        rst;
  logic        iss_valid;
  logic [4:0]  iss_rs, iss_rt, iss_rd;
  logic        iss_rd_we;
  logic        iss_stall;
  logic        a_valid, b_valid;
  logic [4:0]  a_addr, b_addr;
  logic [31:0] a_data, b_data;
  logic        a_ready, b_ready;
  logic        WriteEnable;
  logic [4:0]  DAddress;
  logic [31:0] DData;
  logic [31:0] busy;

  regfile_wb_ctrl #(.DATA_BITS(32), .ADDR_BITS(5)) dut (
    .clk(clk), .rst(rst),
    .iss_valid(iss_valid), .iss_rs(iss_rs), .iss_rt(iss_rt), .iss_rd(iss_rd), .iss_rd_we(iss_rd_we),
    .iss_stall(iss_stall),
    .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready),
    .WriteEnable(WriteEnable), .DAddress(DAddress), .DData(DData), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    else n_pass++;
  endtask

  // Reference model: pending-write set, expected write port, contention preference.
  bit [31:0] m_busy;
  bit        m_we;
  bit [4:0]  m_da;
  bit [31:0] m_dd;
  bit        m_known;
  bit        m_pref_a;
  bit        m_ear, m_ebr, m_est;
  logic      cap_ar, cap_br, cap_st;

  task automatic step(input string tag);
    bit [31:0] nb;
    bit [4:0]  wa;
    #3;
    if (rst) begin
      m_ear = 1'b0; m_ebr = 1'b0;
    end else if (a_valid && b_valid) begin
      m_ear = m_pref_a; m_ebr = !m_pref_a;
    end else begin
      m_ear = a_valid; m_ebr = b_valid;
    end
    m_est = iss_valid && (m_busy[iss_rs] || m_busy[iss_rt] || (iss_rd_we && m_busy[iss_rd]));
    cap_ar = a_ready; cap_br = b_ready; cap_st = iss_stall;
    chk({tag, ":a_ready"}, 32'(a_ready), 32'(m_ear));
    chk({tag, ":b_ready"}, 32'(b_ready), 32'(m_ebr));
    chk({tag, ":iss_stall"}, 32'(iss_stall), 32'(m_est));
    if (rst) begin
      m_busy = '0; m_we = 1'b0; m_da = '0; m_dd = '0; m_known = 1'b1; m_pref_a = 1'b1;
    end else begin
      nb = m_busy;
      if (m_we) nb[m_da] = 1'b0;
      if (iss_valid && !m_est && iss_rd_we && iss_rd != 5'd0) nb[iss_rd] = 1'b1;
      m_busy = nb;
      if (a_valid && b_valid) m_pref_a = !m_ear;
      if (m_ear || m_ebr) begin
        wa   = m_ear ? a_addr : b_addr;
        m_we = (wa != 5'd0);
        if (wa != 5'd0) begin
          m_da = wa; m_dd = m_ear ? a_data : b_data; m_known = 1'b1;
        end else begin
          m_known = 1'b0;
        end
      end else begin
        m_we = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    chk({tag, ":WriteEnable"}, 32'(WriteEnable), 32'(m_we));
    chk({tag, ":busy"}, busy, m_busy);
    if (m_known) begin
      chk({tag, ":DAddress"}, 32'(DAddress), 32'(m_da));
      chk({tag, ":DData"}, DData, m_dd);
    end
  endtask

  typedef struct {
    bit rst; bit av; bit [4:0] aa; bit [31:0] ad; bit bv; bit [4:0] ba; bit [31:0] bd;
    bit iv; bit [4:0] rs; bit [4:0] rt; bit [4:0] rd; bit rdwe;
    bit ear; bit ebr; bit est;
    bit ewe; bit [4:0] eda; bit [31:0] edd; bit [31:0] ebusy; bit chk_dd;
  } vec_t;

  vec_t tab[17];

  initial begin
    bit hold_a, hold_b;
    // rst av aa ad bv ba bd iv rs rt rd rdwe | ready_a ready_b stall | we daddr ddata busy check_dd
    tab[0]  = '{1'b1,1'b1,5'd3,32'hAA,1'b0,5'd0,32'h0,1'b0,5'd0,5'd0,5'd0,1'b0, 1'b0,1'b0,1'b0, 1'b0,5'd0,32'h0,32'h0,1'b1};
    tab[1]  = '{1'b0,1'b1,5'd5,32'h1234,1'b0,5'd0,32'h0,1'b0,5'd0,5'd0,5'd0,1'b0, 1'b1,1'b0,1'b0, 1'b1,5'd5,32'h1234,32'h0,1'b1};
    tab[2]  = '{1'b0,1'b0,5'd0,32'h0,1'b0,5'd0,32'h0,1'b0,5'd0,5'd0,5'd0,1'b0, 1'b0,1'b0,1'b0, 1'b0,5'd5,32'h1234,32'h0,1'b1};
    tab[3]  = '{1'b0,1'b1,5'd1,32'h11,1'b1,5'd2,32'h22,1'b0,5'd0,5'd0,5'd0,1'b0, 1'b1,1'b0,1'b0, 1'b1,5'd1,32'h11,32'h0,1'b1};
    tab[4]  = '{1'b0,1'b1,5'd1,32'h11,1'b1,5'd2,32'h22,1'b0,5'd0,5'd0,5'd0,1'b0, 1'b0,1'b1,1'b0, 1'b1,5'd2,32'h22,32'h0,1'b1};
    tab[5]  = '{1'b0,1'b1,5'd1,32'h11,1'b1,5'd2,32'h22,1'b0,5'd0,5'd0,5'd0,1'b0, 1'b1,1'b0,1'b0, 1'b1,5'd1,32'h11,32'h0,1'b1};
    tab[6]  = '{1'b0,1'b0,5'd0,32'h0,1'b1,5'd0,32'h99,1'b1,5'd0,5'd0,5'd0,1'b1, 1'b0,1'b1,1'b0, 1'b0,5'd0,32'h0,32'h0,1'b0};
    tab[7]  = '{1'b0,1'b0,5'd0,32'h0,1'b0,5'd0,32'h0,1'b1,5'd1,5'd2,5'd7,1'b1, 1'b0,1'b0,1'b0, 1'b0,5'd0,32'h0,32'h80,1'b0};
    tab[8]  = '{1'b0,1'b0,5'd0,32'h0,1'b0,5'd0,32'h0,1'b1,5'd7,5'd0,5'd3,1'b0, 1'b0,1'b0,1'b1, 1'b0,5'd0,32'h0,32'h80,1'b0};
    tab[9]  = '{1'b0,1'b1,5'd7,32'h77,1'b0,5'd0,32'h0,1'b1,5'd7,5'd0,5'd3,1'b0, 1'b1,1'b0,1'b1, 1'b1,5'd7,32'h77,32'h80,1'b1};
    tab[10] = '{1'b0,1'b0,5'd0,32'h0,1'b0,5'd0,32'h0,1'b1,5'd7,5'd0,5'd3,1'b0, 1'b0,1'b0,1'b1, 1'b0,5'd7,32'h77,32'h0,1'b1};
    tab[11] = '{1'b0,1'b0,5'd0,32'h0,1'b0,5'd0,32'h0,1'b1,5'd7,5'd0,5'd3,1'b0, 1'b0,1'b0,1'b0, 1'b0,5'd7,32'h77,32'h0,1'b1};
    tab[12] = '{1'b0,1'b1,5'd7,32'h55,1'b0,5'd0,32'h0,1'b0,5'd0,5'd0,5'd0,1'b0, 1'b1,1'b0,1'b0, 1'b1,5'd7,32'h55,32'h0,1'b1};
    tab[13] = '{1'b0,1'b0,5'd0,32'h0,1'b0,5'd0,32'h0,1'b1,5'd0,5'd0,5'd7,1'b1, 1'b0,1'b0,1'b0, 1'b0,5'd7,32'h55,32'h80,1'b1};
    tab[14] = '{1'b1,1'b1,5'd4,32'h44,1'b0,5'd0,32'h0,1'b0,5'd0,5'd0,5'd0,1'b0, 1'b0,1'b0,1'b0, 1'b0,5'd0,32'h0,32'h0,1'b1};
    tab[15] = '{1'b0,1'b0,5'd0,32'h0,1'b0,5'd0,32'h0,1'b0,5'd0,5'd0,5'd0,1'b0, 1'b0,1'b0,1'b0, 1'b0,5'd0,32'h0,32'h0,1'b1};
    tab[16] = '{1'b0,1'b1,5'd2,32'h21,1'b1,5'd3,32'h31,1'b0,5'd0,5'd0,5'd0,1'b0, 1'b1,1'b0,1'b0, 1'b1,5'd2,32'h21,32'h0,1'b1};

    rst = 1'b1; iss_valid = 1'b0; iss_rs = '0; iss_rt = '0; iss_rd = '0; iss_rd_we = 1'b0;
    a_valid = 1'b0; a_addr = '0; a_data = '0; b_valid = 1'b0; b_addr = '0; b_data = '0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 17; i++) begin
      rst = tab[i].rst; a_valid = tab[i].av; a_addr = tab[i].aa; a_data = tab[i].ad;
      b_valid = tab[i].bv; b_addr = tab[i].ba; b_data = tab[i].bd;
      iss_valid = tab[i].iv; iss_rs = tab[i].rs; iss_rt = tab[i].rt; iss_rd = tab[i].rd; iss_rd_we = tab[i].rdwe;
      step($sformatf("vec%0d", i));
      chk($sformatf("vec%0d:tab_a_ready", i), 32'(cap_ar), 32'(tab[i].ear));
      chk($sformatf("vec%0d:tab_b_ready", i), 32'(cap_br), 32'(tab[i].ebr));
      chk($sformatf("vec%0d:tab_stall", i), 32'(cap_st), 32'(tab[i].est));
      chk($sformatf("vec%0d:tab_we", i), 32'(WriteEnable), 32'(tab[i].ewe));
      chk($sformatf("vec%0d:tab_busy", i), busy, tab[i].ebusy);
      if (tab[i].chk_dd) begin
        chk($sformatf("vec%0d:tab_daddr", i), 32'(DAddress), 32'(tab[i].eda));
        chk($sformatf("vec%0d:tab_ddata", i), DData, tab[i].edd);
      end
    end

    // Random traffic: a requester not granted keeps valid and payload stable.
    hold_a = 1'b0; hold_b = 1'b0;
    for (int c = 0; c < 800; c++) begin
      rst = ($urandom_range(0, 63) == 0);
      if (!hold_a) begin
        a_valid = ($urandom_range(0, 1) == 1);
        a_addr  = 5'($urandom_range(0, 7));
        a_data  = $urandom;
      end
      if (!hold_b) begin
        b_valid = ($urandom_range(0, 1) == 1);
        b_addr  = 5'($urandom_range(0, 7));
        b_data  = $urandom;
      end
      iss_valid = ($urandom_range(0, 1) == 1);
      iss_rs    = 5'($urandom_range(0, 7));
      iss_rt    = 5'($urandom_range(0, 7));
      iss_rd    = 5'($urandom_range(0, 7));
      iss_rd_we = ($urandom_range(0, 3) != 0);
      step($sformatf("rnd%0d", c));
      hold_a = a_valid && !m_ear && !rst;
      hold_b = b_valid && !m_ebr && !rst;
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
